rf_wport_arbiter: RTL and testbench

Arbitrates the register file's single write port between the in-order pipeline writeback stage and a long-latency functional unit, such as a multi-cycle mul/div or a load-miss return path. Long-latency results are buffered in a small FIFO. A 32-entry pending scoreboard drives a decode-stage hazard stall, so no instruction reads or overwrites a register whose result is still in flight. The block sits between writeback and the register file's write inputs (we3/a3/wd3).

---
 rtl/rf_wport_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rf_wport_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a pending scoreboard for decode hazards. Define RF_WPORT_FAIR_EN to bound FIFO starvation.
module rf_wport_arbiter #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [4:0]      ll_rd,
    input  logic [XLEN-1:0] ll_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_rd_we,
    output logic            hz_stall,
    output logic            wb_stall,
    output logic            rf_we,
    output logic [4:0]      rf_a3,
    output logic [XLEN-1:0] rf_wd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [4:0]      rd_mem_q   [DEPTH];
    logic [4:0]      rd_mem_d   [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pending_q, pending_d;

    logic            fifo_nonempty;
    logic            can_push;
    logic            wb_active;
    logic            force_fifo;
    logic            grant_wb;
    logic            grant_fifo;
    logic            push;
    logic            issue_set;
    logic            issue_ok;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign fifo_nonempty = (count_q != '0);
    assign can_push      = (count_q != CW'(DEPTH));
    assign wb_active     = wb_we && (wb_rd != 5'd0);
    assign head_rd       = rd_mem_q[head_q];
    assign head_data     = data_mem_q[head_q];
    assign issue_ok      = !pending_q[iss_rd];

`ifdef RF_WPORT_FAIR_EN
    logic [1:0] starve_q, starve_d;

    // After three lost cycles the oldest result takes the port and writeback holds.
    assign force_fifo = (starve_q == 2'd3) && fifo_nonempty;

    always_comb begin
        starve_d = starve_q;
        if (!fifo_nonempty || grant_fifo) begin
            starve_d = 2'd0;
        end else begin
            starve_d = starve_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 2'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_fifo = 1'b0;
`endif

    assign grant_wb   = wb_active && !force_fifo;
    assign grant_fifo = fifo_nonempty && !grant_wb;
    assign push       = ll_valid && can_push && (ll_rd != 5'd0);
    assign issue_set  = iss_valid && issue_ok && (iss_rd != 5'd0);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        pending_d  = pending_q;

        if (grant_fifo) begin
            head_d             = head_q + PW'(1);
            pending_d[head_rd] = 1'b0;
        end

        if (push) begin
            rd_mem_d[tail_q]   = ll_rd;
            data_mem_d[tail_q] = ll_data;
            tail_d             = tail_q + PW'(1);
        end

        case ({push, grant_fifo})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new issue to the register being drained must win over the clear.
        if (issue_set) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    // Outputs are held at their idle values for as long as reset is asserted.
    always_comb begin
        rf_we     = 1'b0;
        rf_a3     = 5'd0;
        rf_wd     = '0;
        wb_stall  = 1'b0;
        ll_ready  = 1'b1;
        iss_ready = 1'b1;
        hz_stall  = 1'b0;
        if (rst_n) begin
            if (grant_wb) begin
                rf_we = 1'b1;
                rf_a3 = wb_rd;
                rf_wd = wb_data;
            end else if (grant_fifo) begin
                rf_we = 1'b1;
                rf_a3 = head_rd;
                rf_wd = head_data;
            end
            wb_stall  = force_fifo;
            ll_ready  = can_push;
            iss_ready = issue_ok;
            hz_stall  = pending_q[id_rs1] | pending_q[id_rs2] | (id_rd_we & pending_q[id_rd]);
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: queue/array model checked every cycle,
// plus directed vectors with literal expectations.
module tb_rf_wport_arbiter;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;
`ifdef RF_WPORT_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ll_valid;
   logic            ll_ready;
   logic [4:0]      ll_rd;
   logic [XLEN-1:0] ll_data;
   logic            iss_valid;
   logic [4:0]      iss_rd;
   logic            iss_ready;
   logic [4:0]      id_rs1;
   logic [4:0]      id_rs2;
   logic [4:0]      id_rd;
   logic            id_rd_we;
   logic            hz_stall;
   logic            wb_stall;
   logic            rf_we;
   logic [4:0]      rf_a3;
   logic [XLEN-1:0] rf_wd;

   rf_wport_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
      .hz_stall(hz_stall), .wb_stall(wb_stall),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checkCount = 0;
   int failCount  = 0;

   // Single place where every comparison is counted and reported
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   // Model: results waiting in arrival order, registers in flight, cycles the oldest result has waited
   entry_t modelQ[$];
   bit     modelPend[32];
   int     modelStarve = 0;

   bit     nextValid = 1'b0;
   bit     nextPop, nextPush, nextSet;
   entry_t nextEntry;
   logic [4:0] nextSetRd;
   int     nextStarve;

   // Clearing the model when reset asserts mirrors the architectural drop of all buffered results
   always @(negedge rst_n) begin
      modelQ.delete();
      foreach (modelPend[i]) modelPend[i] = 1'b0;
      modelStarve = 0;
      nextValid = 1'b0;
   end

   // Compare every cycle at the falling edge, then decide what the next rising edge will do
   always @(negedge clk) begin
      bit wbAct, haveEnt, forced, fifoGets;
      bit expWe, expLlReady, expIssReady, expHz;
      logic [4:0]  expA3;
      logic [31:0] expWd;
      nextValid = 1'b0;
      if (!rst_n) begin
         checkOutput("reset rf_we", rf_we, 0);
         checkOutput("reset wb_stall", wb_stall, 0);
         checkOutput("reset hz_stall", hz_stall, 0);
         checkOutput("reset ll_ready", ll_ready, 1);
         checkOutput("reset iss_ready", iss_ready, 1);
      end else begin
         wbAct    = wb_we && (wb_rd != 0);
         haveEnt  = modelQ.size() > 0;
         forced   = FAIR && (modelStarve >= 3) && haveEnt;
         fifoGets = haveEnt && (!wbAct || forced);
         expWe = 1'b0; expA3 = 5'd0; expWd = 32'd0;
         if (fifoGets) begin
            expWe = 1'b1; expA3 = modelQ[0].rd; expWd = modelQ[0].data;
         end else if (wbAct) begin
            expWe = 1'b1; expA3 = wb_rd; expWd = wb_data;
         end
         expLlReady  = modelQ.size() < DEPTH;
         expIssReady = !modelPend[iss_rd];
         expHz       = modelPend[id_rs1] || modelPend[id_rs2] || (id_rd_we && modelPend[id_rd]);
         checkOutput("model rf_we", rf_we, expWe);
         checkOutput("model rf_a3", rf_a3, expA3);
         checkOutput("model rf_wd", rf_wd, expWd);
         checkOutput("model wb_stall", wb_stall, forced);
         checkOutput("model ll_ready", ll_ready, expLlReady);
         checkOutput("model iss_ready", iss_ready, expIssReady);
         checkOutput("model hz_stall", hz_stall, expHz);
         nextPop    = fifoGets;
         nextPush   = ll_valid && expLlReady && (ll_rd != 0);
         nextEntry  = '{rd: ll_rd, data: ll_data};
         nextSet    = iss_valid && expIssReady && (iss_rd != 0);
         nextSetRd  = iss_rd;
         nextStarve = (!haveEnt || fifoGets) ? 0 : modelStarve + 1;
         nextValid  = 1'b1;
      end
   end

   // Commit model state; a new issue lands after the drain clear so it survives
   always @(posedge clk) begin
      if (rst_n && nextValid) begin
         if (nextPop) begin
            modelPend[modelQ[0].rd] = 1'b0;
            void'(modelQ.pop_front());
         end
         if (nextPush) modelQ.push_back(nextEntry);
         if (nextSet) modelPend[nextSetRd] = 1'b1;
         modelStarve = nextStarve;
         nextValid = 1'b0;
      end
   end

   // Drive one cycle of inputs just after the rising edge, return at the falling edge
   task automatic applyStimulus(input bit we, input logic [4:0] wrd, input logic [31:0] wdata,
                                input bit llv, input logic [4:0] lrd, input logic [31:0] ldata,
                                input bit isv, input logic [4:0] isrd);
      @(posedge clk);
      #1;
      wb_we = we; wb_rd = wrd; wb_data = wdata;
      ll_valid = llv; ll_rd = lrd; ll_data = ldata;
      iss_valid = isv; iss_rd = isrd;
      @(negedge clk);
   endtask

   // Watchdog so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      rst_n = 1'b0;
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
      ll_valid = 1'b0; ll_rd = 5'd0; ll_data = '0;
      iss_valid = 1'b0; iss_rd = 5'd0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_rd_we = 1'b0;
      #3;
      checkOutput("por rf_we forced low", rf_we, 0);
      checkOutput("por ll_ready", ll_ready, 1);
      checkOutput("por iss_ready", iss_ready, 1);
      @(posedge clk);
      #2;
      wb_we = 1'b0;
      rst_n = 1'b1;

      // Writeback passthrough
      applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      checkOutput("wb rf_we", rf_we, 1);
      checkOutput("wb rf_a3", rf_a3, 5);
      checkOutput("wb rf_wd", rf_wd, 32'hDEADBEEF);
      applyStimulus(1, 0, 32'h11111111, 0, 0, 0, 0, 0);
      checkOutput("wb x0 rf_we", rf_we, 0);
      checkOutput("wb x0 rf_a3", rf_a3, 0);

      // Issue, hazard, then result
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
      checkOutput("issue7 iss_ready", iss_ready, 1);
      id_rs1 = 5'd7;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 7);
      checkOutput("rs1=7 hz_stall", hz_stall, 1);
      checkOutput("rd7 pending iss_ready", iss_ready, 0);
      applyStimulus(0, 0, 0, 1, 7, 32'h1234, 0, 0);
      checkOutput("ll7 accept ll_ready", ll_ready, 1);
      checkOutput("ll7 no bypass rf_we", rf_we, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("ll7 drain rf_we", rf_we, 1);
      checkOutput("ll7 drain rf_a3", rf_a3, 7);
      checkOutput("ll7 drain rf_wd", rf_wd, 32'h1234);
      checkOutput("ll7 drain hz_stall still", hz_stall, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("ll7 after hz_stall", hz_stall, 0);
      checkOutput("ll7 after rf_we", rf_we, 0);
      id_rs1 = 5'd0;

      // FIFO full while writeback owns the port, then in-order drain
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      applyStimulus(1, 1, 32'hAAAA0001, 1, 3, 32'h33, 0, 0);
      checkOutput("full a ll_ready", ll_ready, 1);
      checkOutput("full a rf_a3", rf_a3, 1);
      applyStimulus(1, 1, 32'hAAAA0001, 1, 4, 32'h44, 0, 0);
      checkOutput("full b ll_ready", ll_ready, 1);
      applyStimulus(1, 1, 32'hAAAA0001, 1, 5, 32'h55, 0, 0);
      checkOutput("full c ll_ready", ll_ready, 0);
      checkOutput("full c rf_a3", rf_a3, 1);
      applyStimulus(0, 0, 0, 1, 5, 32'h55, 0, 0);
      checkOutput("drain1 ll_ready", ll_ready, 0);
      checkOutput("drain1 rf_a3", rf_a3, 3);
      checkOutput("drain1 rf_wd", rf_wd, 32'h33);
      applyStimulus(0, 0, 0, 1, 5, 32'h55, 0, 0);
      checkOutput("drain2 ll_ready", ll_ready, 1);
      checkOutput("drain2 rf_a3", rf_a3, 4);
      checkOutput("drain2 rf_wd", rf_wd, 32'h44);
      // rd 5 was never issued: still written, and a same-cycle issue of 5 must stick
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
      checkOutput("drain3 rf_a3", rf_a3, 5);
      checkOutput("drain3 rf_wd", rf_wd, 32'h55);
      checkOutput("drain3 iss_ready", iss_ready, 1);
      id_rd = 5'd5; id_rd_we = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
      checkOutput("set-wins hz_stall", hz_stall, 1);
      checkOutput("set-wins iss_ready", iss_ready, 0);
      checkOutput("drained rf_we", rf_we, 0);
      id_rd = 5'd0; id_rd_we = 1'b0;

      // Issue of a register still in flight is held until its drain
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
      checkOutput("issue9 iss_ready", iss_ready, 1);
      applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9);
      checkOutput("hold9 iss_ready", iss_ready, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
      checkOutput("drain9 rf_a3", rf_a3, 9);
      checkOutput("drain9 iss_ready", iss_ready, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
      checkOutput("reissue9 iss_ready", iss_ready, 1);
      id_rs2 = 5'd9;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
      checkOutput("reissue9 hz_stall", hz_stall, 1);
      id_rs2 = 5'd0;

      // Starvation: one buffered entry against continuous writeback
      applyStimulus(1, 2, 32'hBBBB0002, 1, 10, 32'hAA, 0, 0);
      checkOutput("starve accept rf_a3", rf_a3, 2);
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1, 2, 32'hBBBB0002, 0, 0, 0, 0, 0);
         checkOutput("starve wait rf_a3", rf_a3, 2);
         checkOutput("starve wait wb_stall", wb_stall, 0);
      end
      applyStimulus(1, 2, 32'hBBBB0002, 0, 0, 0, 0, 0);
      checkOutput("starve 4th rf_a3", rf_a3, FAIR ? 10 : 2);
      checkOutput("starve 4th wb_stall", wb_stall, FAIR ? 1 : 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("starve after rf_we", rf_we, FAIR ? 0 : 1);

      // Asynchronous reset with two results buffered and 3, 4 in flight
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      applyStimulus(1, 1, 32'hCCCC0001, 1, 3, 32'h3333, 0, 4);
      applyStimulus(1, 1, 32'hCCCC0001, 1, 4, 32'h4444, 0, 4);
      id_rs1 = 5'd3;
      applyStimulus(1, 1, 32'hCCCC0001, 0, 0, 0, 0, 4);
      checkOutput("prereset ll_ready", ll_ready, 0);
      checkOutput("prereset hz_stall", hz_stall, 1);
      checkOutput("prereset iss_ready", iss_ready, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async rf_we", rf_we, 0);
      checkOutput("async ll_ready", ll_ready, 1);
      checkOutput("async hz_stall", hz_stall, 0);
      checkOutput("async iss_ready", iss_ready, 1);
      @(posedge clk);
      #2;
      wb_we = 1'b0; ll_valid = 1'b0; iss_valid = 1'b0;
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 9);
      checkOutput("postreset rf_we", rf_we, 0);
      checkOutput("postreset hz_stall", hz_stall, 0);
      checkOutput("postreset iss_ready", iss_ready, 1);
      checkOutput("postreset ll_ready", ll_ready, 1);
      id_rs1 = 5'd0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
